// File: rtl/res_stream_out.sv
// res_stream_out: drains the RES RAM after inference and sends each word out as an
// AXI-Stream master. A 2-entry FIFO absorbs the RAM read latency and downstream stalls.
//
// state  | meaning
// IDLE   | waiting for Start
// STREAM | issuing RAM reads and sending words downstream
// DONE   | one-cycle Done pulse, then back to IDLE
module res_stream_out #(
   parameter int width          = 8,
   parameter int RES_depth_bits = 6,
   parameter int NUM_WORDS      = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      Start,
   output logic                      Done,
   output logic                      busy,
   output logic                      RES_read_en,
   output logic [RES_depth_bits-1:0] RES_read_address,
   input  logic [width-1:0]          RES_read_data_out,
   output logic                      M_AXIS_TVALID,
   input  logic                      M_AXIS_TREADY,
   output logic [width-1:0]          M_AXIS_TDATA,
   output logic                      M_AXIS_TLAST
);

   localparam int              CW       = $clog2(NUM_WORDS + 1);
   localparam logic [CW-1:0]   N_WORDS  = CW'(NUM_WORDS);
   localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     issue_cnt;
   logic [CW-1:0]     sent_cnt;
   logic              inflight;
   logic [width-1:0]  fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic              issue;
   logic              push;
   logic              pop;
   logic [2:0]        occ_next;

   // Counting this cycle's pop keeps one word per cycle flowing with TREADY high.
   always_comb begin
      push     = inflight;
      pop      = (fifo_cnt != 2'd0) && M_AXIS_TREADY;
      occ_next = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
      issue    = (state == STREAM) && (issue_cnt < N_WORDS) && (occ_next < 3'd2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = STREAM;
         STREAM:  if (pop && (sent_cnt == LAST_IDX)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_cnt   <= '0;
         sent_cnt    <= '0;
         inflight    <= 1'b0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         inflight <= issue;
         if ((state == IDLE) && Start) begin
            issue_cnt <= '0;
            sent_cnt  <= '0;
         end else begin
            if (issue) issue_cnt <= issue_cnt + CW'(1);
            if (pop)   sent_cnt  <= sent_cnt + CW'(1);
         end
         if (push) begin
            fifo_mem[wr_ptr] <= RES_read_data_out;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         if (push && !pop)      fifo_cnt <= fifo_cnt + 2'd1;
         else if (pop && !push) fifo_cnt <= fifo_cnt - 2'd1;
      end
   end

   always_comb begin
      Done             = (state == DONE);
      busy             = (state != IDLE);
      RES_read_en      = issue;
      RES_read_address = issue ? RES_depth_bits'(issue_cnt) : '0;
      M_AXIS_TVALID    = (fifo_cnt != 2'd0);
      M_AXIS_TDATA     = fifo_mem[rd_ptr];
      M_AXIS_TLAST     = (fifo_cnt != 2'd0) && (sent_cnt == LAST_IDX);
   end

   fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (fifo_cnt == 2'd2)));

endmodule

// File: tb/tb_res_stream_out.sv
// Bench for res_stream_out: scenario table over a 64-word instance plus hand-written
// single-word and reset-mid-stream sequences; a queue of expected words is the reference.
module tb_res_stream_out;

   localparam int NW = 64;

   typedef struct {
      int mode;        // 0 ready high, 1 pattern 1001, 2 random, 3 stalled for 'stall' cycles
      int stall;
      bit spur;        // extra Start pulses at word 20 and in the DONE cycle
      bit rnd;         // random RAM contents instead of i+1
      int exp_lat;     // cycles from Start edge to first TVALID
      int exp_dones;
      int exp_reads;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       start, done, busy, rd_en, tvalid, tready, tlast;
   logic [5:0] rd_addr;
   logic [7:0] rd_data, tdata;
   logic [7:0] ram [NW];

   logic       s_start, s_done, s_busy, s_rd_en, s_tvalid, s_tready, s_tlast;
   logic [5:0] s_rd_addr;
   logic [7:0] s_rdata, s_tdata, s_ram0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int reads, beats, done_cnt, first_valid, first_hs, last_hs, done_cyc, start_cyc;
   bit held_v;
   logic [7:0] held_d;
   logic       held_l;
   logic [7:0] exp_q [$];

   res_stream_out #(.width(8), .RES_depth_bits(6), .NUM_WORDS(NW)) dut (
      .clk(clk), .reset(reset), .Start(start), .Done(done), .busy(busy),
      .RES_read_en(rd_en), .RES_read_address(rd_addr), .RES_read_data_out(rd_data),
      .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata),
      .M_AXIS_TLAST(tlast)
   );

   res_stream_out #(.width(8), .RES_depth_bits(6), .NUM_WORDS(1)) dut1 (
      .clk(clk), .reset(reset), .Start(s_start), .Done(s_done), .busy(s_busy),
      .RES_read_en(s_rd_en), .RES_read_address(s_rd_addr), .RES_read_data_out(s_rdata),
      .M_AXIS_TVALID(s_tvalid), .M_AXIS_TREADY(s_tready), .M_AXIS_TDATA(s_tdata),
      .M_AXIS_TLAST(s_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];
   always @(posedge clk) if (s_rd_en) s_rdata <= s_ram0;

   task automatic chk_eq(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference monitor of the 64-word instance, sampled mid-cycle.
   task automatic sample();
      if (reset) begin
         held_v = 1'b0;
         return;
      end
      if (held_v) begin
         chk_eq("hold_valid", int'(tvalid), 1);
         chk_eq("hold_data", int'(tdata), int'(held_d));
         chk_eq("hold_last", int'(tlast), int'(held_l));
      end
      held_v = tvalid && !tready;
      held_d = tdata;
      held_l = tlast;
      if (tvalid && first_valid < 0) first_valid = cyc;
      if (tvalid && tready) begin
         chk_eq("beat_in_range", int'(beats < NW), 1);
         if (exp_q.size() > 0) begin
            chk_eq("tdata", int'(tdata), int'(exp_q[0]));
            chk_eq("tlast", int'(tlast), int'(exp_q.size() == 1));
            void'(exp_q.pop_front());
         end
         if (beats == 0) first_hs = cyc;
         last_hs = cyc;
         beats++;
      end
      if (!tvalid) chk_eq("tlast_idle", int'(tlast), 0);
      if (rd_en) begin
         chk_eq("rd_addr", int'(rd_addr), reads % NW);
         chk_eq("rd_in_stream", int'(busy && !done), 1);
         reads++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic prep(input bit rnd);
      exp_q.delete();
      for (int i = 0; i < NW; i++) begin
         ram[i] = rnd ? 8'($urandom) : 8'(i + 1);
         exp_q.push_back(ram[i]);
      end
      reads = 0; beats = 0; done_cnt = 0; first_valid = -1;
      first_hs = 0; last_hs = 0; done_cyc = 0;
   endtask

   task automatic run_case(input vec_t v);
      int k;
      bit last;
      bit spur_hit;
      prep(v.rnd);
      start = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
      chk_eq("busy_after_start", int'(busy), 1);
      k = 0; last = 1'b0; spur_hit = 1'b0;
      while (k < 3000) begin
         case (v.mode)
            0:       tready = 1'b1;
            1:       tready = (k % 4 == 0) || (k % 4 == 3);
            2:       tready = 1'($urandom_range(0, 1));
            default: tready = (k >= v.stall);
         endcase
         if (v.mode == 3 && k == v.stall) begin
            chk_eq("stall_reads", reads, 2);
            chk_eq("stall_valid", int'(tvalid), 1);
            chk_eq("stall_data", int'(tdata), int'(ram[0]));
         end
         if (v.spur && ((beats == 20 && !spur_hit) || done)) begin
            start = 1'b1;
            spur_hit = 1'b1;
         end
         if (done) last = 1'b1;
         tick();
         start = 1'b0;
         k++;
         if (last) break;
      end
      tready = 1'b1;
      chk_eq("done_seen", int'(last), 1);
      chk_eq("all_words_sent", exp_q.size(), 0);
      chk_eq("first_valid_latency", first_valid - start_cyc, v.exp_lat);
      chk_eq("done_after_last_beat", done_cyc - last_hs, 1);
      if (v.mode == 0) chk_eq("back_to_back", last_hs - first_hs, NW - 1);
      chk_eq("busy_after_done", int'(busy), 0);
      repeat (8) tick();
      chk_eq("done_count", done_cnt, v.exp_dones);
      chk_eq("read_count", reads, v.exp_reads);
      chk_eq("idle_valid", int'(tvalid), 0);
   endtask

   initial begin
      vec_t tbl [6];
      int   rk;
      tbl[0] = '{0, 0,  1'b0, 1'b0, 2, 1, NW};
      tbl[1] = '{1, 0,  1'b0, 1'b0, 2, 1, NW};
      tbl[2] = '{3, 10, 1'b0, 1'b0, 2, 1, NW};
      tbl[3] = '{0, 0,  1'b1, 1'b0, 2, 1, NW};
      tbl[4] = '{2, 0,  1'b0, 1'b1, 2, 1, NW};
      tbl[5] = '{2, 0,  1'b1, 1'b1, 2, 1, NW};

      start = 1'b0; tready = 1'b0; s_start = 1'b0; s_tready = 1'b0; s_ram0 = 8'h00;
      held_v = 1'b0; held_d = 8'h00; held_l = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk_eq("rst_done", int'(done), 0);
      chk_eq("rst_busy", int'(busy), 0);
      chk_eq("rst_rd_en", int'(rd_en), 0);
      chk_eq("rst_rd_addr", int'(rd_addr), 0);
      chk_eq("rst_tvalid", int'(tvalid), 0);
      chk_eq("rst_tlast", int'(tlast), 0);
      chk_eq("rst_tdata", int'(tdata), 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) run_case(tbl[i]);

      // Single-word instance: the only beat carries TLAST.
      s_tready = 1'b1; s_ram0 = 8'hA5; s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk_eq("nw1_busy", int'(s_busy), 1);
      chk_eq("nw1_rd_en", int'(s_rd_en), 1);
      chk_eq("nw1_rd_addr", int'(s_rd_addr), 0);
      tick();
      chk_eq("nw1_valid_early", int'(s_tvalid), 0);
      chk_eq("nw1_no_second_read", int'(s_rd_en), 0);
      tick();
      chk_eq("nw1_valid", int'(s_tvalid), 1);
      chk_eq("nw1_data", int'(s_tdata), 32'hA5);
      chk_eq("nw1_last", int'(s_tlast), 1);
      tick();
      chk_eq("nw1_done", int'(s_done), 1);
      chk_eq("nw1_valid_after", int'(s_tvalid), 0);
      tick();
      chk_eq("nw1_done_low", int'(s_done), 0);
      chk_eq("nw1_busy_low", int'(s_busy), 0);

      // Reset while word 30 is on the bus, then a clean rerun from address 0.
      prep(1'b0);
      tready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      rk = 0;
      while (beats < 30 && rk < 500) begin
         tick();
         rk++;
      end
      chk_eq("reached_word30", beats, 30);
      reset = 1'b1;
      #1;
      chk_eq("midrst_tvalid", int'(tvalid), 0);
      chk_eq("midrst_busy", int'(busy), 0);
      chk_eq("midrst_rd_en", int'(rd_en), 0);
      chk_eq("midrst_tlast", int'(tlast), 0);
      tick();
      reset = 1'b0;
      tick();
      chk_eq("postrst_busy", int'(busy), 0);
      run_case(tbl[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
